// File: rtl/pld_dispatch.sv
// pld_dispatch
//
// Single-producer, WIDTH-consumer valid/ready dispatcher. Every accepted beat is
// routed by dst_s into a private 2-entry FIFO for that output, so a stalled
// consumer only back-pressures beats aimed at itself. rdy_s is computed from
// registered FIFO counts only and never looks at v_rdy_m.
//
// Optional feature macro: PLD_DISPATCH_BCAST_EN adds bcast_s. A broadcast beat
// is pushed into every output FIFO at once and needs room in all of them.
//
// Ports
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   vld_s     input valid
//   rdy_s     input ready
//   pld_s     input payload
//   dst_s     destination output index, qualified by vld_s
//   bcast_s   broadcast request (PLD_DISPATCH_BCAST_EN only)
//   v_vld_m   per-output valid
//   v_rdy_m   per-output ready
//   v_pld_m   per-output payload (head of each FIFO)
//   err_drop  one-cycle pulse after a beat with out-of-range dst_s was dropped

module pld_dispatch #(
   parameter type PLD_TYPE = logic,
   parameter int  WIDTH    = 3,
   parameter int  DW       = $clog2(WIDTH)   // derived, leave at default
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   vld_s,
   output logic                   rdy_s,
   input  PLD_TYPE                pld_s,
   input  logic [DW-1:0]          dst_s,
`ifdef PLD_DISPATCH_BCAST_EN
   input  logic                   bcast_s,
`endif
   output logic [WIDTH-1:0]       v_vld_m,
   input  logic [WIDTH-1:0]       v_rdy_m,
   output PLD_TYPE [WIDTH-1:0]    v_pld_m,
   output logic                   err_drop
);

   logic [1:0]       cnt [WIDTH];
   logic [WIDTH-1:0] wptr;
   logic [WIDTH-1:0] rptr;
   PLD_TYPE          mem [WIDTH][2];

   logic [WIDTH-1:0] dst_hot;
   logic [WIDTH-1:0] push;
   logic [WIDTH-1:0] pop;
   logic             in_range;
   logic             sel_full;
   logic             all_open;
   logic             accept;
   logic             drop;

   // Decode dst_s by comparison rather than indexing so that codes >= WIDTH
   // (possible when WIDTH is not a power of two) simply match nothing.
   always_comb begin
      dst_hot  = '0;
      in_range = 1'b0;
      sel_full = 1'b0;
      all_open = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         if (cnt[i] == 2'd2) all_open = 1'b0;
         if (dst_s == DW'(i)) begin
            dst_hot[i] = 1'b1;
            in_range   = 1'b1;
            sel_full   = (cnt[i] == 2'd2);
         end
      end
   end

   // A pop in the same cycle does not reopen a full FIFO; this keeps v_rdy_m
   // out of the rdy_s cone.
   always_comb begin
      rdy_s = in_range ? !sel_full : 1'b1;
`ifdef PLD_DISPATCH_BCAST_EN
      if (vld_s && bcast_s) rdy_s = all_open;
`endif
   end

   always_comb begin
      accept = vld_s && rdy_s;
      push   = '0;
      drop   = 1'b0;
      if (accept) begin
`ifdef PLD_DISPATCH_BCAST_EN
         if (bcast_s) push = '1;
         else
`endif
         if (in_range) push = dst_hot;
         else          drop = 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         v_vld_m[i] = (cnt[i] != 2'd0);
         v_pld_m[i] = mem[i][rptr[i]];
      end
      pop = v_vld_m & v_rdy_m;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) cnt[i] <= 2'd0;
         wptr     <= '0;
         rptr     <= '0;
         err_drop <= 1'b0;
      end else begin
         err_drop <= drop;
         for (int i = 0; i < WIDTH; i++) begin
            if (push[i]) wptr[i] <= ~wptr[i];
            if (pop[i])  rptr[i] <= ~rptr[i];
            case ({push[i], pop[i]})
               2'b10:   cnt[i] <= cnt[i] + 2'd1;
               2'b01:   cnt[i] <= cnt[i] - 2'd1;
               default: cnt[i] <= cnt[i];
            endcase
         end
      end
   end

   // Storage is not reset; an entry is only visible once its count covers it.
   always_ff @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (push[i]) mem[i][wptr[i]] <= pld_s;
      end
   end

endmodule

// File: tb/tb_pld_dispatch.sv
module tb_pld_dispatch;
   typedef logic [7:0] pld_t;
   localparam int W = 3;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           vld_s = 1'b0;
   logic           rdy_s;
   pld_t           pld_s = '0;
   logic [1:0]     dst_s = '0;
   logic           bcast_s = 1'b0;
   logic [W-1:0]   v_vld_m;
   logic [W-1:0]   v_rdy_m = '0;
   pld_t [W-1:0]   v_pld_m;
   logic           err_drop;

   int checks = 0;
   int failures = 0;

   // reference model: one queue per output
   pld_t q[W][$];
   logic exp_err = 1'b0;
   bit   mvalid = 1'b0;
   logic m_rdy;

   always #5 clk = ~clk;

   pld_dispatch #(.PLD_TYPE(pld_t), .WIDTH(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .vld_s(vld_s),
      .rdy_s(rdy_s),
      .pld_s(pld_s),
      .dst_s(dst_s),
`ifdef PLD_DISPATCH_BCAST_EN
      .bcast_s(bcast_s),
`endif
      .v_vld_m(v_vld_m),
      .v_rdy_m(v_rdy_m),
      .v_pld_m(v_pld_m),
      .err_drop(err_drop)
   );

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   function logic model_rdy();
`ifdef PLD_DISPATCH_BCAST_EN
      if (vld_s && bcast_s) begin
         for (int i = 0; i < W; i++) if (q[i].size() == 2) return 1'b0;
         return 1'b1;
      end
`endif
      if (int'(dst_s) < W) return (q[dst_s].size() != 2);
      return 1'b1;
   endfunction

   // Compare, then advance the model to what the next edge must produce.
   always @(negedge clk) begin
      #2;
      if (mvalid) begin
         chk("rdy_s", rdy_s, model_rdy());
         chk("err_drop", err_drop, exp_err);
         for (int i = 0; i < W; i++) begin
            chk("v_vld_m", v_vld_m[i], q[i].size() != 0);
            if (q[i].size() != 0) chk("v_pld_m", v_pld_m[i], q[i][0]);
         end
      end
      if (!rst_n) begin
         for (int i = 0; i < W; i++) q[i].delete();
         exp_err = 1'b0;
         mvalid  = 1'b1;
      end else begin
         m_rdy   = model_rdy();
         exp_err = 1'b0;
         for (int i = 0; i < W; i++)
            if (q[i].size() != 0 && v_rdy_m[i]) void'(q[i].pop_front());
         if (vld_s && m_rdy) begin
`ifdef PLD_DISPATCH_BCAST_EN
            if (bcast_s) begin
               for (int i = 0; i < W; i++) q[i].push_back(pld_s);
            end else
`endif
            if (int'(dst_s) < W) q[dst_s].push_back(pld_s);
            else exp_err = 1'b1;
         end
      end
   end

   task automatic drive(logic v, logic [1:0] d, pld_t p, logic [W-1:0] r);
      @(negedge clk);
      vld_s   = v;
      dst_s   = d;
      pld_s   = p;
      v_rdy_m = r;
      bcast_s = 1'b0;
   endtask

   initial begin
      // reset
      repeat (3) @(negedge clk);
      #3;
      chk("rst_rdy", rdy_s, 1);
      chk("rst_vld", v_vld_m, 0);
      chk("rst_err", err_drop, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // in-order delivery on output 1
      drive(1, 1, 8'hA1, 3'b111);
      drive(1, 1, 8'hA2, 3'b111); #3;
      chk("t1_vld", v_vld_m, 3'b010);
      chk("t1_a1", v_pld_m[1], 8'hA1);
      drive(1, 1, 8'hA3, 3'b111); #3;
      chk("t1_a2", v_pld_m[1], 8'hA2);
      drive(0, 0, 8'h00, 3'b111); #3;
      chk("t1_a3", v_pld_m[1], 8'hA3);
      chk("t1_vld3", v_vld_m, 3'b010);
      drive(0, 0, 8'h00, 3'b111); #3;
      chk("t1_empty", v_vld_m, 3'b000);

      // output 0 stalled, output 2 still flows, full boundary
      drive(1, 0, 8'hB0, 3'b110);
      drive(1, 0, 8'hB1, 3'b110);
      drive(1, 0, 8'hB2, 3'b110); #3;
      chk("full_rdy", rdy_s, 0);
      drive(1, 2, 8'hC0, 3'b110); #3;
      chk("hol_rdy", rdy_s, 1);
      drive(1, 2, 8'hC1, 3'b110); #3;
      chk("hol_c0", v_pld_m[2], 8'hC0);
      drive(1, 0, 8'hB2, 3'b111); #3;
      chk("popfull_rdy", rdy_s, 0);
      drive(1, 0, 8'hB2, 3'b110); #3;
      chk("reopen_rdy", rdy_s, 1);
      chk("head_b1", v_pld_m[0], 8'hB1);
      repeat (4) drive(0, 0, 8'h00, 3'b111);
      #3;
      chk("t2_drained", v_vld_m, 3'b000);

      // out-of-range destination
      drive(1, 3, 8'hD0, 3'b111); #3;
      chk("oor_rdy", rdy_s, 1);
      drive(0, 0, 8'h00, 3'b111); #3;
      chk("oor_err", err_drop, 1);
      chk("oor_vld", v_vld_m, 3'b000);
      drive(0, 0, 8'h00, 3'b111); #3;
      chk("oor_err_clr", err_drop, 0);

      // reset with every FIFO full
      for (int d = 0; d < W; d++) begin
         drive(1, 2'(d), 8'(8'h10 + d), 3'b000);
         drive(1, 2'(d), 8'(8'h20 + d), 3'b000);
      end
      drive(0, 0, 8'h00, 3'b000); #3;
      chk("pre_rst_vld", v_vld_m, 3'b111);
      chk("pre_rst_rdy", rdy_s, 0);
      drive(0, 0, 8'h00, 3'b000);
      rst_n = 1'b0;
      drive(1, 0, 8'hE0, 3'b000);
      rst_n = 1'b1;
      #3;
      chk("post_rst_vld", v_vld_m, 3'b000);
      chk("post_rst_rdy", rdy_s, 1);
      drive(0, 0, 8'h00, 3'b111); #3;
      chk("post_rst_lat", v_vld_m, 3'b001);
      chk("post_rst_pld", v_pld_m[0], 8'hE0);

`ifdef PLD_DISPATCH_BCAST_EN
      repeat (3) drive(0, 0, 8'h00, 3'b111);
      drive(1, 0, 8'h55, 3'b000);
      bcast_s = 1'b1;
      drive(0, 0, 8'h00, 3'b000); #3;
      chk("bc_vld", v_vld_m, 3'b111);
      for (int i = 0; i < W; i++) chk("bc_pld", v_pld_m[i], 8'h55);
      drive(1, 2, 8'h66, 3'b000);
      drive(1, 0, 8'h77, 3'b000);
      bcast_s = 1'b1; #3;
      chk("bc_block", rdy_s, 0);
      drive(1, 0, 8'h77, 3'b100);
      bcast_s = 1'b1; #3;
      chk("bc_block_pop", rdy_s, 0);
      drive(1, 0, 8'h77, 3'b000);
      bcast_s = 1'b1; #3;
      chk("bc_open", rdy_s, 1);
      repeat (4) drive(0, 0, 8'h00, 3'b111);
`endif

      // mixed traffic against the model
      for (int n = 0; n < 300; n++) begin
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               8'($urandom), 3'($urandom));
`ifdef PLD_DISPATCH_BCAST_EN
         bcast_s = ($urandom_range(0, 3) == 0);
`endif
      end
      repeat (4) drive(0, 0, 8'h00, 3'b111);
      #3;
      chk("final_empty", v_vld_m, 3'b000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
